// File: rtl/alu_bcd_converter.sv
// Sequential binary-to-BCD converter (iterative double-dabble, one bit per clock).
// Optional leading-zero blanking of digitEn is enabled by defining ALU_BCD_LZB_EN.
module alu_bcd_converter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd,
    output logic [DIGITS-1:0]     digitEn,
    output logic                  overflow
);

    localparam int unsigned SW = DIGITS * 4 + 4;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]     LastCnt = CW'(WIDTH - 1);
    localparam logic [DIGITS-1:0] EnReset = DIGITS'(1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [SW-1:0]       scratch_q, scratch_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DIGITS*4-1:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]   en_q, en_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;

    logic [SW-1:0]       adj;
    logic [SW-1:0]       scr_sh;
    logic [WIDTH-1:0]    bin_sh;
    logic [DIGITS*4-1:0] fin_bcd;
    logic                fin_ovf;
    logic [DIGITS-1:0]   fin_en;
`ifdef ALU_BCD_LZB_EN
    logic                lit;
`endif

    // One double-dabble iteration: add-3 correction, then shift the combined register.
    always_comb begin
        adj = scratch_q;
        for (int n = 0; n <= int'(DIGITS); n++) begin
            if (scratch_q[4*n +: 4] >= 4'd5) begin
                adj[4*n +: 4] = scratch_q[4*n +: 4] + 4'd3;
            end
        end
        {scr_sh, bin_sh} = {adj, bin_q} << 1;
        fin_bcd = scr_sh[DIGITS*4-1:0];
        fin_ovf = |scr_sh[SW-1:DIGITS*4];
`ifdef ALU_BCD_LZB_EN
        // Walk from the top digit down; once a nonzero digit is seen, everything below lights.
        lit = fin_ovf;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            lit       = lit | (|fin_bcd[4*i +: 4]) | (i == 0);
            fin_en[i] = lit;
        end
`else
        fin_en = '1;
`endif
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        en_d      = en_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    bin_d     = value;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                bin_d     = bin_sh;
                scratch_d = scr_sh;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    bcd_d  = fin_bcd;
                    en_d   = fin_en;
                    ovf_d  = fin_ovf;
                    done_d = 1'b1;
                    // A start on the completion edge begins the next conversion immediately.
                    if (start) begin
                        bin_d     = value;
                        scratch_d = '0;
                        cnt_d     = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            en_q      <= EnReset;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            en_q      <= en_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign busy     = (state_q == StShift);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign digitEn  = en_q;
    assign overflow = ovf_q;

endmodule
